// File: rtl/relu_out_buffer.sv
// ============================================================================
// relu_out_buffer
// ----------------------------------------------------------------------------
// This stage sits downstream of the 64-input MAC neuron. It works as follows:
//   - Each accepted signed Q8.8 MAC result is passed through ReLU.
//   - The result is registered in a 1-entry stage.
//   - The stage then writes into a first-word-fall-through FIFO.
//   - The next layer drains the FIFO over valid/ready.
// A small FSM (IDLE/RUN/DRAIN/DONE) counts the accepted neurons of a layer. It
// pulses layer_done for one cycle once the last activation has left the FIFO.
//
// Build option:
//   ACT_SAT_EN  defined   -> ReLU6-style clamp of positive values to SAT_MAX
//               undefined -> plain ReLU (SAT_MAX unused)
//
// Ports:
//   clk         in   1   clock, posedge
//   reset       in   1   synchronous, active-high
//   start       in   1   begin a layer (IDLE only)
//   in_valid    in   1   in_data valid
//   in_data     in   16  signed Q8.8 MAC result
//   in_ready    out  1   input accepted this cycle when in_valid is high
//   out_valid   out  1   out_data valid (FIFO not empty)
//   out_data    out  16  activation, unsigned Q8.8 (0 while out_valid is low)
//   out_ready   in   1   consumer takes out_data this cycle
//   neuron_cnt  out  16  neurons accepted in the current layer
//   layer_done  out  1   one-cycle pulse when the layer has fully drained
// ============================================================================
module relu_out_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned NUM_NEURONS = 64,
    parameter logic [15:0] SAT_MAX     = 16'h0600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic [15:0] neuron_cnt,
    output logic        layer_done
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [15:0] LAST_C  = 16'(NUM_NEURONS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          stage_valid_q, stage_valid_d;
    logic [15:0]   stage_data_q, stage_data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [15:0]   mem_q [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [15:0]   act_data;

    // Occupancy includes the stage entry. An accepted word therefore always
    // finds room in the FIFO on the next cycle, so the stage never stalls.
    // The readiness term uses registers only and has no path from out_ready.
    assign in_ready   = (state_q == S_RUN) &&
                        ((fifo_cnt_q + {{AW{1'b0}}, stage_valid_q}) < DEPTH_C);
    assign accept     = in_valid && in_ready;
    assign push       = stage_valid_q;
    assign out_valid  = (fifo_cnt_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign neuron_cnt = cnt_q;
    assign layer_done = (state_q == S_DONE);

    always_comb begin
        act_data = in_data[15] ? '0 : in_data;
`ifdef ACT_SAT_EN
        if (act_data > SAT_MAX) begin
            act_data = SAT_MAX;
        end
`endif
    end

`ifndef ACT_SAT_EN
    logic unused_sat_max;
    assign unused_sat_max = ^SAT_MAX;
`endif

    always_comb begin
        stage_valid_d = accept;
        stage_data_d  = accept ? act_data : stage_data_q;
        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_C) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Uses next-cycle occupancy, so DONE follows the final pop by one cycle.
                if ((fifo_cnt_d == '0) && !stage_valid_d) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= stage_data_q;
        end
    end

endmodule

// File: tb/tb_relu_out_buffer.sv
module tb_relu_out_buffer;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [15:0] in_data;

    logic        m_in_ready, m_out_valid, m_layer_done;
    logic [15:0] m_out_data, m_neuron_cnt;
    logic        s_in_ready, s_out_valid, s_layer_done;
    logic [15:0] s_out_data, s_neuron_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    relu_out_buffer #(.DEPTH(4), .NUM_NEURONS(64), .SAT_MAX(16'h0600)) u_main (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(m_in_ready), .out_valid(m_out_valid),
        .out_data(m_out_data), .out_ready(out_ready),
        .neuron_cnt(m_neuron_cnt), .layer_done(m_layer_done)
    );

    relu_out_buffer #(.DEPTH(4), .NUM_NEURONS(4), .SAT_MAX(16'h0600)) u_small (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(s_in_ready), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_ready(out_ready),
        .neuron_cnt(s_neuron_cnt), .layer_done(s_layer_done)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        vecs[0] = '{16'h0180, 16'h0180};
        vecs[1] = '{16'hFF00, 16'h0000};
        vecs[2] = '{16'h8000, 16'h0000};
        vecs[3] = '{16'h0000, 16'h0000};
        vecs[4] = '{16'h0600, 16'h0600};
`ifdef ACT_SAT_EN
        vecs[5] = '{16'h0700, 16'h0600};
        vecs[6] = '{16'h0601, 16'h0600};
        vecs[7] = '{16'h7FFF, 16'h0600};
`else
        vecs[5] = '{16'h0700, 16'h0700};
        vecs[6] = '{16'h0601, 16'h0601};
        vecs[7] = '{16'h7FFF, 16'h7FFF};
`endif

        // Reset state
        do_reset();
        chk("rst_in_ready",   {15'd0, m_in_ready},   16'd0);
        chk("rst_out_valid",  {15'd0, m_out_valid},  16'd0);
        chk("rst_out_data",   m_out_data,            16'd0);
        chk("rst_neuron_cnt", m_neuron_cnt,          16'd0);
        chk("rst_layer_done", {15'd0, m_layer_done}, 16'd0);

        // Activation table with two-cycle latency per word
        do_start();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            chk("vec_in_ready", {15'd0, m_in_ready}, 16'd1);
            tick();
            in_valid = 1'b0;
            chk("vec_lat1_valid", {15'd0, m_out_valid}, 16'd0);
            tick();
            chk("vec_lat2_valid", {15'd0, m_out_valid}, 16'd1);
            chk("vec_data", m_out_data, vecs[i].exp);
            tick();
            chk("vec_popped", {15'd0, m_out_valid}, 16'd0);
        end
        chk("vec_neuron_cnt", m_neuron_cnt, 16'd8);

        // Backpressure: fill to DEPTH, then drain in order
        do_reset();
        do_start();
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h0010 + 16'(n);
            if (m_in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_accepts",  16'(n), 16'd4);
        chk("fill_in_ready", {15'd0, m_in_ready}, 16'd0);
        chk("fill_head",     m_out_data, 16'h0010);
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_out_valid) begin
                chk("drain_data", m_out_data, 16'h0010 + 16'(k));
                k++;
            end
            tick();
        end
        chk("drain_count", 16'(k), 16'd4);
        chk("drain_neuron_cnt", m_neuron_cnt, 16'd4);

        // Full FIFO: single pop while input is held, refill, order kept
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h0020 + 16'(n);
            if (m_in_ready) n++;
            tick();
        end
        chk("full_accepts", 16'(n), 16'd4);
        out_ready = 1'b1;
        chk("full_pop_head",     m_out_data, 16'h0020);
        chk("full_pop_in_ready", {15'd0, m_in_ready}, 16'd0);
        tick();
        out_ready = 1'b0;
        chk("after_pop_in_ready",  {15'd0, m_in_ready},  16'd1);
        chk("after_pop_out_valid", {15'd0, m_out_valid}, 16'd1);
        chk("after_pop_head",      m_out_data,           16'h0021);
        tick();
        in_valid = 1'b0;
        chk("refull_in_ready", {15'd0, m_in_ready}, 16'd0);
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_out_valid) begin
                chk("full_order", m_out_data, 16'h0021 + 16'(k));
                k++;
            end
            tick();
        end
        chk("full_drain_count", 16'(k), 16'd4);
        chk("full_neuron_cnt", m_neuron_cnt, 16'd9);

        // Reset with queued words (start held too: reset wins)
        do_reset();
        do_start();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = 16'h0030 + 16'(j);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("q3_out_valid",  {15'd0, m_out_valid}, 16'd1);
        chk("q3_neuron_cnt", m_neuron_cnt, 16'd3);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("mid_rst_out_valid",  {15'd0, m_out_valid},  16'd0);
        chk("mid_rst_neuron_cnt", m_neuron_cnt,          16'd0);
        chk("mid_rst_layer_done", {15'd0, m_layer_done}, 16'd0);
        chk("mid_rst_in_ready",   {15'd0, m_in_ready},   16'd0);
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_layer_done", {15'd0, m_layer_done}, 16'd0);
            chk("post_rst_in_ready",   {15'd0, m_in_ready},   16'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("idle_ignores_valid", m_neuron_cnt, 16'd0);
        chk("idle_out_valid", {15'd0, m_out_valid}, 16'd0);

        // Layer completion with NUM_NEURONS=4
        do_reset();
        do_start();
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h0040 + 16'(n);
            if (s_in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        chk("layer_accepts",   16'(n), 16'd4);
        chk("layer_cnt",       s_neuron_cnt, 16'd4);
        chk("drain_in_ready",  {15'd0, s_in_ready},   16'd0);
        chk("drain_no_done",   {15'd0, s_layer_done}, 16'd0);
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            if (s_out_valid) begin
                chk("layer_data", s_out_data, 16'h0040 + 16'(k));
                chk("layer_done_early", {15'd0, s_layer_done}, 16'd0);
                k++;
            end
            tick();
        end
        chk("layer_pops",      16'(k), 16'd4);
        chk("layer_done_hi",   {15'd0, s_layer_done}, 16'd1);
        chk("layer_done_empty", {15'd0, s_out_valid}, 16'd0);
        tick();
        chk("layer_done_lo",   {15'd0, s_layer_done}, 16'd0);
        chk("idle_in_ready",   {15'd0, s_in_ready},   16'd0);
        chk("cnt_held",        s_neuron_cnt, 16'd4);
        do_start();
        chk("cnt_cleared",     s_neuron_cnt, 16'd0);
        chk("run_in_ready",    {15'd0, s_in_ready}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
